// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: holds the PC, fetches 16-bit words over req/ack, and issues them to decode.
// Latency: one cycle from memory ack to instr_valid; at best one instruction every two cycles.
// Backpressure: the fetched word is held in HOLD until dec_ready; no new request is made meanwhile.
//
// Ports:
//   clk, rst                  clock (rising edge) and asynchronous active-low reset
//   imem_req/addr/ack/rdata   instruction memory request/response handshake
//   instr_valid, dec_ready    valid/ready handshake towards decode
//   instr, opcode, pc, pc_link   presented instruction, its opcode, its address, and address + 1
//   redirect, redirect_pc     branch/jump redirect to a new word address
//   illegal                   an unused opcode (1110/1111) was fetched; the core is halted
module instr_fetch #(
   parameter int                  ADDR_W   = 16,
   parameter int                  DATA_W   = 16,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   input  logic              dec_ready,
   output logic [DATA_W-1:0] instr,
   output logic [3:0]        opcode,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_link,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              illegal
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_DRAIN = 3'd2,
      S_HOLD  = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_nxt_state;

   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   w_nxt_pc;
   logic [DATA_W-1:0]   r_instr;
   logic [DATA_W-1:0]   w_nxt_instr;
   logic                r_req;
   logic                w_nxt_req;
   logic                r_vld;
   logic                w_nxt_vld;
   logic                r_illegal;
   logic                w_nxt_illegal;
   logic                r_pend_vld;
   logic                w_nxt_pend_vld;
   logic [ADDR_W-1:0]   r_pend_pc;
   logic [ADDR_W-1:0]   w_nxt_pend_pc;

   logic [ADDR_W-1:0]   w_pc_inc;
   logic                w_rd_illegal;

   // Natural wrap at 2^ADDR_W: 'hFFFF + 1 truncates to 0.
   assign w_pc_inc     = r_pc + ADDR_W'(1);
   // Opcodes 1110 and 1111 share the top three bits 111.
   assign w_rd_illegal = (imem_rdata[DATA_W-1 -: 3] == 3'b111);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      w_nxt_state    = r_state;
      w_nxt_pc       = r_pc;
      w_nxt_instr    = r_instr;
      w_nxt_illegal  = r_illegal;
      w_nxt_pend_vld = r_pend_vld;
      w_nxt_pend_pc  = r_pend_pc;

      case (r_state)
         S_IDLE: begin
            // Any ack seen here belongs to a transaction abandoned by reset.
            w_nxt_state = S_REQ;
         end

         S_REQ: begin
            if (imem_ack) begin
               if (redirect) begin
                  // The returning word is from the wrong path: drop it, refetch at target.
                  w_nxt_pc    = redirect_pc;
                  w_nxt_state = S_REQ;
               end else if (w_rd_illegal) begin
                  w_nxt_illegal = 1'b1;
                  w_nxt_state   = S_HALT;
               end else begin
                  w_nxt_instr = imem_rdata;
                  w_nxt_state = S_HOLD;
               end
            end else if (redirect) begin
               // The request cannot be withdrawn; remember the target and wait out the ack.
               w_nxt_pend_vld = 1'b1;
               w_nxt_pend_pc  = redirect_pc;
               w_nxt_state    = S_DRAIN;
            end
         end

         S_DRAIN: begin
            if (redirect) begin
               w_nxt_pend_vld = 1'b1;
               w_nxt_pend_pc  = redirect_pc;
            end
            if (imem_ack) begin
               // A redirect arriving together with the ack is the newest one and wins.
               if (redirect) begin
                  w_nxt_pc = redirect_pc;
               end else if (r_pend_vld) begin
                  w_nxt_pc = r_pend_pc;
               end
               w_nxt_pend_vld = 1'b0;
               w_nxt_state    = S_REQ;
            end
         end

         S_HOLD: begin
            if (redirect) begin
               w_nxt_pc    = redirect_pc;
               w_nxt_state = S_REQ;
            end else if (dec_ready) begin
               w_nxt_pc    = w_pc_inc;
               w_nxt_state = S_REQ;
            end
         end

         S_HALT: begin
            if (redirect) begin
               w_nxt_illegal = 1'b0;
               w_nxt_pc      = redirect_pc;
               w_nxt_state   = S_REQ;
            end
         end

         default: begin
            w_nxt_state = S_IDLE;
         end
      endcase

      // Handshake outputs are decoded from the next state so they register alongside it;
      // req and valid are therefore mutually exclusive by construction.
      w_nxt_req = (w_nxt_state == S_REQ) || (w_nxt_state == S_DRAIN);
      w_nxt_vld = (w_nxt_state == S_HOLD);
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_req      <= 1'b0;
         r_vld      <= 1'b0;
         r_illegal  <= 1'b0;
         r_pend_vld <= 1'b0;
         r_pend_pc  <= RESET_PC;
      end else begin
         r_pc       <= w_nxt_pc;
         r_instr    <= w_nxt_instr;
         r_req      <= w_nxt_req;
         r_vld      <= w_nxt_vld;
         r_illegal  <= w_nxt_illegal;
         r_pend_vld <= w_nxt_pend_vld;
         r_pend_pc  <= w_nxt_pend_pc;
      end
   end

   // The PC register doubles as the fetch address: it only changes on ack or in HOLD/HALT,
   // so the address is stable for the whole of REQ and DRAIN.
   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign instr_valid = r_vld;
   assign instr       = r_instr;
   assign opcode      = r_instr[DATA_W-1 -: 4];
   assign pc          = r_pc;
   assign pc_link     = w_pc_inc;
   assign illegal     = r_illegal;

endmodule
